// File: rtl/byte_block_packer.sv
// Packs a byte stream into NUM_BLOCOS-byte blocks for the XOR hash stage.
// It has one fill register and one output register. A block that closes while the
// output register is stalled waits in the fill register.
module byte_block_packer #(
    parameter int unsigned NUM_BLOCOS = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [8*NUM_BLOCOS-1:0]       blk_data,
    output logic [$clog2(NUM_BLOCOS):0]   blk_bytes,
    output logic                          blk_last,
    output logic                          blk_valid,
    input  logic                          blk_ready
);

    localparam int unsigned W  = 8 * NUM_BLOCOS;
    localparam int unsigned CW = (NUM_BLOCOS > 1) ? $clog2(NUM_BLOCOS) : 1;
    localparam int unsigned BW = $clog2(NUM_BLOCOS) + 1;

    logic [W-1:0]  acc_q, acc_d, acc_wr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [BW-1:0] pend_bytes_q, pend_bytes_d;
    logic          pend_last_q, pend_last_d;

    logic [W-1:0]  out_data_q, out_data_d;
    logic [BW-1:0] out_bytes_q, out_bytes_d;
    logic          out_last_q, out_last_d;
    logic          out_valid_q, out_valid_d;

    logic [BW-1:0] bytes_wr;
    logic          accept, close, xfer, slot_free, full;

    assign in_ready  = !pend_q && !rst;
    assign blk_data  = out_data_q;
    assign blk_bytes = out_bytes_q;
    assign blk_last  = out_last_q;
    assign blk_valid = out_valid_q;

    always_comb begin
        acc_wr = acc_q;
        acc_wr[{cnt_q, 3'b000} +: 8] = in_data;
        bytes_wr  = BW'(cnt_q) + BW'(1);
        full      = (cnt_q == CW'(NUM_BLOCOS - 1));
        accept    = in_valid && in_ready;
        close     = accept && (full || in_last);
        xfer      = out_valid_q && blk_ready;
        slot_free = !out_valid_q || blk_ready;
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_bytes_d = pend_bytes_q;
        pend_last_d  = pend_last_q;
        out_data_d   = out_data_q;
        out_bytes_d  = out_bytes_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;

        if (pend_q) begin
            // Output is necessarily full here; release on its transfer.
            if (xfer) begin
                out_data_d   = acc_q;
                out_bytes_d  = pend_bytes_q;
                out_last_d   = pend_last_q;
                out_valid_d  = 1'b1;
                pend_d       = 1'b0;
                pend_bytes_d = '0;
                pend_last_d  = 1'b0;
                acc_d        = '0;
                cnt_d        = '0;
            end
        end else if (close) begin
            if (slot_free) begin
                out_data_d  = acc_wr;
                out_bytes_d = bytes_wr;
                out_last_d  = in_last;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d        = acc_wr;
                pend_d       = 1'b1;
                pend_bytes_d = bytes_wr;
                pend_last_d  = in_last;
            end
        end else begin
            if (accept) begin
                acc_d = acc_wr;
                cnt_d = cnt_q + CW'(1);
            end
            if (xfer) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_bytes_q <= '0;
            pend_last_q  <= 1'b0;
            out_data_q   <= '0;
            out_bytes_q  <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_bytes_q <= pend_bytes_d;
            pend_last_q  <= pend_last_d;
            out_data_q   <= out_data_d;
            out_bytes_q  <= out_bytes_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_byte_block_packer.sv
// Randomized and directed bench for byte_block_packer.
// A queue of closed-but-not-yet-taken blocks serves as the reference.
module tb_byte_block_packer;

    localparam int NB = 64;
    localparam int W  = 8 * NB;
    localparam int BW = $clog2(NB) + 1;

    logic          clk;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [W-1:0]  blk_data;
    logic [BW-1:0] blk_bytes;
    logic          blk_last;
    logic          blk_valid;
    logic          blk_ready;

    byte_block_packer #(.NUM_BLOCOS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_bytes (blk_bytes),
        .blk_last  (blk_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           bytes;
        bit           last;
    } blk_t;

    // Blocks that have closed but not yet been taken by the consumer, oldest first.
    blk_t         exp_q[$];
    logic [W-1:0] cur_data;
    int           cur_n;
    bit           after_rst;
    int           n_checks;
    int           n_pass;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: drive at negedge, check state from the last edge, advance the model.
    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit l,
                        input bit rdy);
        blk_t nb;
        bit   acc;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_last = l; blk_ready = rdy;
        #1;
        check("in_ready", W'(in_ready), W'(!r && exp_q.size() < 2));
        check("blk_valid", W'(blk_valid), W'(exp_q.size() > 0));
        if (after_rst) begin
            check("rst_data", blk_data, '0);
            check("rst_bytes", W'(blk_bytes), '0);
            check("rst_last", W'(blk_last), '0);
        end
        if (blk_valid === 1'b1 && exp_q.size() > 0) begin
            check("blk_data", blk_data, exp_q[0].data);
            check("blk_bytes", W'(blk_bytes), W'(exp_q[0].bytes));
            check("blk_last", W'(blk_last), W'(exp_q[0].last));
        end
        acc = v && (in_ready === 1'b1);
        if (r) begin
            exp_q.delete();
            cur_data  = '0;
            cur_n     = 0;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (blk_valid === 1'b1 && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) begin
                cur_data[8*cur_n +: 8] = d;
                cur_n++;
                if (cur_n == NB || l) begin
                    nb.data  = cur_data;
                    nb.bytes = cur_n;
                    nb.last  = l;
                    exp_q.push_back(nb);
                    cur_data = '0;
                    cur_n    = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, rdy);
    endtask

    initial begin
        int rdy_pct;
        n_checks = 0; n_pass = 0;
        cur_data = '0; cur_n = 0; after_rst = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Full block ending on byte 64 with in_last.
        for (int i = 0; i < NB; i++) step(1'b0, 1'b1, 8'(i), i == NB - 1, 1'b1);
        idle(3, 1'b1);

        // Short block, then in_last without in_valid.
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h0F, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h77, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Backpressure into the pending state, then release.
        for (int i = 0; i < 2 * NB; i++) step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Continuous streaming.
        for (int i = 0; i < 3 * NB; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1);
        idle(3, 1'b1);

        // Reset mid-fill.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < NB; i++) step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Reset while a block is pending.
        for (int i = 0; i < 2 * NB; i++) step(1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(5, 1'b1);

        // Random traffic with varying consumer pressure.
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) rdy_pct = $urandom_range(10, 100);
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) != 0,
                 8'($urandom),
                 $urandom_range(0, 23) == 0,
                 $urandom_range(1, 100) <= rdy_pct);
        end
        idle(2 * NB, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/byte_block_packer.md
Name: byte_block_packer

Overview:
- Upstream feeder for the 64-byte XOR hash stage.
- Accepts a byte stream over a valid/ready handshake and packs the bytes into 512-bit blocks. Short final blocks are zero-padded; zero padding is neutral for the XOR hash.
- Presents each completed block on a valid/ready output. Its data bus connects directly to the hash stage's 512-bit "in" input.
- Double-buffered, with one fill register and one output register, so it streams at one byte per clock with no bubbles while the consumer keeps up.

Parameters:
- NUM_BLOCOS, 64, number of bytes per block. Block width is 8*NUM_BLOCOS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_last  input  1  this byte is the final byte of the message; qualified by in_valid.
- in_ready  output  1  the block can accept a byte this cycle.
- blk_data  output  8*NUM_BLOCOS  packed block; byte k occupies bits [8k+7:8k], and the first byte received is at bits [7:0].
- blk_bytes  output  $clog2(NUM_BLOCOS)+1  number of real bytes in the block, 1..NUM_BLOCOS.
- blk_last  output  1  the block ends a message (closed by in_last).
- blk_valid  output  1  blk_data, blk_bytes and blk_last are valid.
- blk_ready  input  1  the consumer takes the block this cycle.

Behaviour:
- Handshakes:
  - An input byte is accepted when in_valid && in_ready.
  - An output block transfers when blk_valid && blk_ready.
- Fill stage state: accumulator acc (8*NUM_BLOCOS bits), count cnt (0..NUM_BLOCOS-1), pend flag.
  - On byte accept, the byte is written into lane cnt of acc.
- Block close:
  - A block closes on the accept of byte number NUM_BLOCOS (cnt == NUM_BLOCOS-1), or on accept of any byte with in_last=1.
  - On close, cnt and acc clear to 0. All lanes not written in that block are therefore zero.
- Output slot free condition: !blk_valid || blk_ready.
- Close while the slot is free:
  - On the same edge, blk_data takes the closed block (the byte accepted this cycle included).
  - blk_bytes takes cnt+1; blk_last takes in_last; blk_valid goes to 1.
  - Latency: blk_valid is high the cycle after the closing byte is accepted.
- Close while the slot is occupied and not draining:
  - The closed block stays in the fill stage (acc, byte count and last flag held), and pend goes to 1.
- Pend release:
  - While pend=1, in_ready = 0.
  - On the edge of the next output transfer, the pending block moves into the output register, blk_valid stays 1 and pend clears.
- in_ready:
  - in_ready = !pend && !rst.
  - Bytes keep being accepted while the output register is full, until the fill stage itself closes.
- Output stability: while blk_valid && !blk_ready, blk_data, blk_bytes and blk_last hold stable.
- blk_valid falls on a transfer edge only if no block moves in on that edge.
- Simultaneous events:
  - Close and output transfer on the same edge: the new block loads directly, blk_valid stays 1, and there is no bubble.
  - in_last on byte number NUM_BLOCOS: a single block with blk_bytes=NUM_BLOCOS, blk_last=1, and no empty trailing block.
- No empty blocks are ever emitted. in_last without in_valid is ignored.
- Reset (synchronous, at any point including mid-fill or mid-pend):
  - blk_valid=0, blk_data=0, blk_bytes=0, blk_last=0, cnt=0, acc=0, pend=0.
  - Partial data is discarded. in_ready=0 while rst is high.

Test Plan:
- Full block: blk_ready=1, send bytes 0x00..0x3F, in_last on 0x3F → one block, blk_data[7:0]=0x00, blk_data[511:504]=0x3F, blk_bytes=64, blk_last=1. Downstream hash out=0x00.
- Short block: send 0xA5, 0x5A, 0x0F with in_last on 0x0F → blk_data[23:0]=0x0F5AA5, bits [511:24]=0, blk_bytes=3, blk_last=1. Hash out=0xF0.
- Backpressure: blk_ready=0, send 128 bytes of 0x11 with no in_last →
  - First block valid and held stable.
  - in_ready drops the cycle after the 128th byte is accepted.
  - Raise blk_ready: first block transfers, the second appears with blk_valid continuous, then in_ready returns to 1.
- Streaming: blk_ready=1, in_valid=1 continuously for 192 bytes → in_ready never falls, and exactly 3 blocks appear, each with blk_bytes=64, blk_last=0.
- Reset mid-fill: send 10 bytes, assert rst for 1 cycle, then send 64 bytes 0xFF → no block from the first 10 bytes. One block of all 0xFF follows (hash out=0x00) with blk_bytes=64.
- Reset while pend=1 with blk_valid=1 → the next cycle has blk_valid=0, in_ready=1, and no stale block is emitted afterwards.
